// File: rtl/mult_issue_sched_pkg.sv
// Shared width helpers for the multiplier issue scheduler.
package mult_sched_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int id_width(input int req);
    return (req < 2) ? 1 : clog2(req);
  endfunction

  // The cooldown counter only has to hold II-1.
  function automatic int cd_width(input int ii);
    return (ii < 2) ? 1 : clog2(ii);
  endfunction

endpackage

// File: rtl/mult_issue_sched_arb.sv
// Combinational round-robin picker: the first requester at or after ptr wins.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int REQ = 4,
  localparam int IDW = id_width(REQ)
) (
  input  logic [REQ-1:0] req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [REQ-1:0] gnt,
  output logic [IDW-1:0] gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < REQ; k++) begin
        idx = (int'(ptr) + k) % REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mult_issue_sched.sv
// Shares one multi-cycle multiplier among REQ requesters, enforcing the
// initiation interval and returning ID-tagged products after a fixed latency.
module mult_issue_sched
  import mult_sched_pkg::*;
#(
  parameter int N   = 8,
  parameter int M   = 8,
  parameter int REQ = 4,
  parameter int II  = 4,
  parameter int LAT = 5,
  localparam int IDW = id_width(REQ),
  localparam int CDW = cd_width(II)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ-1:0]   req_sign,
  input  logic [REQ*N-1:0] req_a,
  input  logic [REQ*M-1:0] req_b,
  output logic             mult_start,
  output logic             mult_sign,
  output logic [N-1:0]     mult_a,
  output logic [M-1:0]     mult_b,
  input  logic [N+M-1:0]   mult_out,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [N+M-1:0]   rsp_data
);

  logic [CDW-1:0] cd_q, cd_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           issue_ok;
  logic           accept;
  logic [REQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;

  logic           start_q, sign_q;
  logic [N-1:0]   a_q;
  logic [M-1:0]   b_q;

  logic [LAT-1:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [N+M-1:0] rsp_data_q;

  // No grant while reset is asserted, so nothing is handed out that reset then drops.
  assign issue_ok = (cd_q == '0) && !rst;

  rr_arbiter #(.REQ(REQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (issue_ok),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    cd_d  = cd_q;
    ptr_d = ptr_q;
    if (accept) begin
      cd_d  = CDW'(II - 1);
      ptr_d = (gnt_id == IDW'(REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (cd_q != '0) begin
      cd_d = cd_q - CDW'(1);
    end
  end

  // Operands hold between accepts; the multiplier may sample them late.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q    <= '0;
      ptr_q   <= '0;
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      cd_q    <= cd_d;
      ptr_q   <= ptr_d;
      start_q <= accept;
      if (accept) begin
        sign_q <= req_sign[gnt_id];
        a_q    <= req_a[int'(gnt_id)*N +: N];
        b_q    <= req_b[int'(gnt_id)*M +: M];
      end
    end
  end

  // Stage 0 is visible during the start cycle; the head lines up with mult_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q   <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_vld_q[0] <= accept;
      tag_id_q[0]  <= gnt_id;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      rsp_valid_q <= tag_vld_q[LAT-1];
      rsp_id_q    <= tag_id_q[LAT-1];
      if (tag_vld_q[LAT-1]) rsp_data_q <= mult_out;
    end
  end

  assign mult_start = start_q;
  assign mult_sign  = sign_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_mult_issue_sched.sv
// Scoreboard bench for mult_issue_sched, run at II=4 and II=1 side by side.
module tb_mult_issue_sched;
  localparam int N = 8, M = 8, REQ = 4, LAT = 5, IDW = 2, P = N + M;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    int             id;
    logic [P-1:0]   data;
    int             due;
  } exp_t;

  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL g%0d %s: got %0h expected %0h at t=%0t", g, nm, act, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] ref_prod(input logic [N-1:0] a, input logic [M-1:0] b, input logic s);
    int ai, bi, p;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    p  = ai * bi;
    return p[P-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int IIG = (g == 0) ? 4 : 1;

    logic             rst;
    logic [REQ-1:0]   req_valid, req_ready, req_sign;
    logic [REQ*N-1:0] req_a;
    logic [REQ*M-1:0] req_b;
    logic             mult_start, mult_sign;
    logic [N-1:0]     mult_a;
    logic [M-1:0]     mult_b;
    logic [P-1:0]     mult_out;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [P-1:0]     rsp_data;

    mult_issue_sched #(.N(N), .M(M), .REQ(REQ), .II(IIG), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
      .req_a(req_a), .req_b(req_b),
      .mult_start(mult_start), .mult_sign(mult_sign), .mult_a(mult_a), .mult_b(mult_b),
      .mult_out(mult_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // Pipelined multiplier stand-in: product readable LAT-1 edges after the start edge.
    logic [P-1:0] pipe [LAT-1];
    always @(posedge clk) begin : stub
      logic [P-1:0] ea, eb;
      ea = {{M{mult_sign & mult_a[N-1]}}, mult_a};
      eb = {{N{mult_sign & mult_b[M-1]}}, mult_b};
      for (int k = LAT - 2; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= mult_start ? P'(ea * eb) : P'($urandom);
    end
    assign mult_out = pipe[LAT-2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           last_acc = -1000;
    int           rr_next  = 0;
    int           acc_cnt [REQ] = '{default: 0};
    logic [N-1:0] exp_a = '0;
    logic [M-1:0] exp_b = '0;
    logic         exp_s = 1'b0;
    exp_t         sbq[$];

    // Reference: accepts spaced >= II cycles apart, rotating priority after the last winner.
    always @(negedge clk) begin : model
      logic [REQ-1:0] er;
      int win;
      er  = '0;
      win = -1;
      if (!rst && (cyc - last_acc >= IIG)) begin
        for (int k = 0; k < REQ; k++)
          if (win < 0 && req_valid[(rr_next + k) % REQ]) win = (rr_next + k) % REQ;
      end
      if (win >= 0) er[win] = 1'b1;
      chk(g, "req_ready", 64'(req_ready), 64'(er));
      chk(g, "mult_start", 64'(mult_start), 64'(cyc == last_acc + 1));
      if (cyc == last_acc + 1) begin
        chk(g, "mult_a", 64'(mult_a), 64'(exp_a));
        chk(g, "mult_b", 64'(mult_b), 64'(exp_b));
        chk(g, "mult_sign", 64'(mult_sign), 64'(exp_s));
      end
      if (rst) begin
        last_acc = -1000;
        rr_next  = 0;
      end else if (win >= 0) begin
        last_acc = cyc;
        rr_next  = (win + 1) % REQ;
        exp_a    = req_a[win*N +: N];
        exp_b    = req_b[win*M +: M];
        exp_s    = req_sign[win];
        sbq.push_back('{id: win, data: ref_prod(exp_a, exp_b, exp_s), due: cyc + 1 + LAT});
        acc_cnt[win]++;
      end
    end

    always @(negedge clk) begin : monitor
      exp_t e;
      if (rsp_valid) begin
        if (sbq.size() == 0) chk(g, "rsp_unexpected", 64'(rsp_valid), 64'(0));
        else begin
          e = sbq.pop_front();
          chk(g, "rsp_id", 64'(rsp_id), 64'(e.id));
          chk(g, "rsp_data", 64'(rsp_data), 64'(e.data));
          chk(g, "rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk(g, "rsp_missing", 64'(rsp_valid), 64'(1));
      end
      if (rst) sbq.delete();
    end

    int handled [REQ] = '{default: 0};

    task automatic drive(input logic [REQ-1:0] mask, input int dens);
      @(posedge clk);
      #1;
      for (int i = 0; i < REQ; i++) begin
        if (acc_cnt[i] != handled[i]) begin
          handled[i]   = acc_cnt[i];
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && mask[i] && ($urandom_range(99) < dens)) begin
          req_valid[i]      = 1'b1;
          req_sign[i]       = 1'($urandom_range(1));
          req_a[i*N +: N]   = N'($urandom);
          req_b[i*M +: M]   = M'($urandom);
        end
      end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [M-1:0] b, input logic s);
      req_valid[i]    = 1'b1;
      req_sign[i]     = s;
      req_a[i*N +: N] = a;
      req_b[i*M +: M] = b;
    endtask

    task automatic one(input int i, input logic [N-1:0] a, input logic [M-1:0] b, input logic s);
      int n0;
      n0 = acc_cnt[i];
      drive('0, 0);
      set_req(i, a, b, s);
      for (int t = 0; t < 100 && acc_cnt[i] == n0; t++) drive('0, 0);
      if (acc_cnt[i] == n0) chk(g, "accept_timeout", 64'(acc_cnt[i]), 64'(n0 + 1));
    endtask

    initial begin : stim
      int n0, n1;
      rst = 1'b1;
      req_valid = '0; req_sign = '0; req_a = '0; req_b = '0;
      repeat (3) begin
        @(negedge clk);
        chk(g, "rst_mult_start", 64'(mult_start), 64'(0));
        chk(g, "rst_mult_sign", 64'(mult_sign), 64'(0));
        chk(g, "rst_mult_a", 64'(mult_a), 64'(0));
        chk(g, "rst_mult_b", 64'(mult_b), 64'(0));
        chk(g, "rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk(g, "rst_rsp_id", 64'(rsp_id), 64'(0));
        chk(g, "rst_rsp_data", 64'(rsp_data), 64'(0));
        chk(g, "rst_req_ready", 64'(req_ready), 64'(0));
      end
      @(posedge clk);
      #1 rst = 1'b0;

      one(2, 8'd7, 8'd9, 1'b0);
      repeat (10) drive('0, 0);
      one(1, 8'hFE, 8'h03, 1'b1);
      repeat (10) drive('0, 0);
      repeat (24) drive(4'b1111, 100);
      repeat (20) drive('0, 0);
      repeat (16) drive(4'b1001, 100);
      repeat (20) drive('0, 0);
      repeat (400) drive(REQ'($urandom), 50);
      repeat (24) drive('0, 0);

      // Two operations in flight, then a one-cycle reset before either returns.
      n0 = acc_cnt[0];
      n1 = acc_cnt[1];
      drive('0, 0);
      set_req(0, N'($urandom), M'($urandom), 1'b0);
      set_req(1, N'($urandom), M'($urandom), 1'b1);
      for (int t = 0; t < 50 && (acc_cnt[0] == n0 || acc_cnt[1] == n1); t++) drive('0, 0);
      if (acc_cnt[1] == n1) chk(g, "flight_timeout", 64'(acc_cnt[1]), 64'(n1 + 1));
      rst = 1'b1;
      drive('0, 0);
      rst = 1'b0;
      repeat (12) drive(4'b1111, 100);
      repeat (30) drive('0, 0);
      chk(g, "sb_drained", 64'(sbq.size()), 64'(0));
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      repeat (5000) @(posedge clk);
    join_any
    if (done_cnt != 2) chk(0, "run_timeout", 64'(done_cnt), 64'(2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_issue_sched.md
# mult_issue_sched

Round-robin issue scheduler that shares one multi-cycle multiplier (`mcmult2o`) among `REQ` independent requesters. It accepts operand requests over valid/ready handshakes and enforces the multiplier's initiation interval. It drives the multiplier's `start`/`sign`/`a`/`b` inputs and returns each product tagged with the requester ID after a fixed latency. It sits between requesting datapath blocks and a single `mcmult2o` instance.

## Interface
- `N`, 8: width of operand a.
- `M`, 8: width of operand b.
- `REQ`, 4: number of requesters; ≥2.
- `II`, 4: multiplier initiation interval in cycles; ≥1.
- `LAT`, 5: cycles from `mult_start` high to valid product on `mult_out`; ≥1.
- `IDW`, `$clog2(REQ)`: requester ID width (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in REQ: request pending, one bit per requester.
- `req_ready` out REQ: one-hot accept, combinational.
- `req_sign` in REQ: signed-multiply flag per requester.
- `req_a` in REQ*N: packed a operands; requester i uses bits [i*N +: N].
- `req_b` in REQ*M: packed b operands; requester i uses bits [i*M +: M].
- `mult_start` out 1: start pulse to the multiplier.
- `mult_sign` out 1: sign bit to the multiplier.
- `mult_a` out N: a operand to the multiplier.
- `mult_b` out M: b operand to the multiplier.
- `mult_out` in N+M: product from the multiplier.
- `rsp_valid` out 1: product valid, one-cycle pulse.
- `rsp_id` out IDW: requester ID of the product.
- `rsp_data` out N+M: product.

## Operation
- Cooldown counter `cd` (width covering II-1).
  - Issue is allowed when `cd==0`.
  - On accept, `cd` loads II-1.
  - Otherwise `cd` decrements while nonzero.
- Arbitration (only when issue is allowed and |`req_valid`):
  - Round-robin pointer `ptr`. The winner is the first valid requester at or after `ptr`, wrapping modulo REQ.
  - `req_ready[winner]`=1 in that cycle. All other `req_ready` bits are 0.
  - When issue is not allowed, all `req_ready` bits are 0.
- On accept:
  - `ptr` ← winner+1, wrapping to 0 after REQ-1.
  - `mult_sign`/`mult_a`/`mult_b` are registered from the winner's inputs.
  - `mult_start` is a one-cycle registered pulse.
- Operand hold: `mult_a`/`mult_b`/`mult_sign` hold their values until the next accept, because the multiplier may sample them over several cycles.
- Tag pipeline: a LAT-deep shift register of {valid, id}. It is loaded with {1, winner id} in the cycle `mult_start` is high. At its head, `rsp_valid`/`rsp_id` are registered and `rsp_data` is registered from `mult_out`.
- Responses have no backpressure. Requesters must accept `rsp_valid` whenever it pulses.
- Requester rule: `req_valid` and operands must stay stable until `req_ready`. The block does not check this.
- Reset values:
  - `mult_start`=0, `mult_sign`=0, `mult_a`=0, `mult_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `ptr`=0, `cd`=0, all tag valids=0.
- Reset mid-operation: all in-flight tags are discarded, so no `rsp_valid` is produced for operations started before reset. The multiplier itself has no reset; its residual output is ignored.
- Arithmetic: the product width is always N+M. Sign is passed through untouched, and the block does no arithmetic on operands.

## Timing
- Accept in cycle T:
  - `mult_start`=1 in T+1.
  - `rsp_valid`=1 in T+1+LAT.
- Total request-to-response latency is LAT+1 cycles.
- Minimum spacing between accepts is exactly II cycles, so with II=1 accepts can occur back-to-back.
- First accept after reset: earliest in the first cycle `rst` is low.
- Responses return in issue order. At most one `rsp_valid` per cycle and at most ceil(LAT/II) operations in flight.
- A request arriving while `cd≠0` waits. Arbitration happens in the first cycle `cd==0`, using the `req_valid` values of that cycle.
- Simultaneous events:
  - A response retiring and a new accept in the same cycle are independent and both occur.
  - A lone requester is re-granted each allowed slot regardless of `ptr`.

## Structure
- Package `mult_sched_pkg`: an ID-width function (`clog2`) and the cooldown width calculation. There is no state enum; the only state is `cd`/`ptr`.
- Sub-module `rr_arbiter` (parameter `REQ`):
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and binary `gnt_id`.
  - Purely combinational; the scheduler owns `ptr`.
- Tag pipeline and output registers use plain registered logic with synchronous reset. The codebase `flop` module has no reset and must not be used for them.
- A top-level test wrapper instantiates `mult_issue_sched` plus `mcmult2o` with matching `II`/`LAT`.

## Test plan
- Reset then idle: hold `rst`=1 for 3 cycles, with no requests. All outputs stay 0 and `req_ready`=0000.
- Single request: requester 2 sends a=8'd7, b=8'd9, sign=0, accepted at T.
  - `mult_start` in T+1.
  - `rsp_valid` in T+6 with `rsp_id`=2 and `rsp_data`=16'd63.
- Round-robin contention: all four requesters valid continuously with II=4. Grants go 0,1,2,3,0 at cycles T, T+4, T+8, T+12, T+16, and responses return in that ID order.
- Signed operation: requester 1 sends a=8'hFE (−2), b=8'h03, sign=1. Response is `rsp_data`=16'hFFFA with `rsp_id`=1.
- II=1 back-to-back: requesters 0 and 3 both valid. Grants alternate 0,3,0,3 on consecutive cycles and responses return on consecutive cycles in the same order.
- Reset mid-flight: accept two operations, then assert `rst` for 1 cycle before either response. No `rsp_valid` occurs, and the next grant goes to requester 0.
